// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - soft-start/fade sequencer for the PWM wave_length/high_time inputs
//
// Accepts a ramp command (period, target duty, step) and walks high_time
// toward the target by one step per PWM period. Outputs only change on a
// last_cycle edge, so the PWM never sees a mid-period reconfiguration.
//
// Optional feature macro: PWM_RAMP_DWELL_EN (adds cmd_dwell; RAMP steps only
// every cmd_dwell+1 periods). Default build: a step on every last_cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_wave_length       new PWM period minus 1
//   cmd_target            target high_time
//   cmd_step              per-period step, 0 = jump straight to target
//   cmd_dwell             (PWM_RAMP_DWELL_EN) extra periods between steps
//   abort                 stop ramp, hold current outputs
//   last_cycle            PWM end-of-period pulse
//   wave_length/high_time to the PWM
//   busy                  not IDLE
//   done                  one-cycle pulse when high_time reaches target

module pwm_ramp_ctrl #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] WL_RESET = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_wave_length,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [WIDTH-1:0] cmd_step,
`ifdef PWM_RAMP_DWELL_EN
    input  logic [7:0]       cmd_dwell,
`endif
    input  logic             abort,
    input  logic             last_cycle,
    output logic [WIDTH-1:0] wave_length,
    output logic [WIDTH-1:0] high_time,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RAMP = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lat_wl;
    logic [WIDTH-1:0] lat_tgt;
    logic [WIDTH-1:0] lat_step;

    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_lim;
    logic [WIDTH-1:0] next_ht;
    logic             reach;
    logic             step_en;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // One extra bit on both sums so saturation is decided before any wrap.
    assign up_sum = {1'b0, high_time} + {1'b0, lat_step};
    assign dn_lim = {1'b0, lat_tgt} + {1'b0, lat_step};

    always_comb begin
        next_ht = lat_tgt;
        if (lat_step != '0 && lat_tgt > high_time) begin
            if (up_sum < {1'b0, lat_tgt})
                next_ht = up_sum[WIDTH-1:0];
        end else if (lat_step != '0 && lat_tgt < high_time) begin
            if ({1'b0, high_time} >= dn_lim)
                next_ht = high_time - lat_step;
        end
    end

    assign reach = (next_ht == lat_tgt);

`ifdef PWM_RAMP_DWELL_EN
    logic [7:0] lat_dwell;
    logic [7:0] dwell_cnt;

    // Counts last_cycle pulses since the previous applied step.
    assign step_en = (dwell_cnt == lat_dwell);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_dwell <= '0;
            dwell_cnt <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                lat_dwell <= cmd_dwell;
                dwell_cnt <= '0;
            end else if (state == SYNC && !abort && last_cycle) begin
                dwell_cnt <= '0;
            end else if (state == RAMP && !abort && last_cycle) begin
                if (step_en)
                    dwell_cnt <= '0;
                else
                    dwell_cnt <= dwell_cnt + 8'd1;
            end
        end
    end
`else
    assign step_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            lat_wl      <= '0;
            lat_tgt     <= '0;
            lat_step    <= '0;
            wave_length <= WL_RESET;
            high_time   <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        lat_wl   <= cmd_wave_length;
                        lat_tgt  <= cmd_target;
                        lat_step <= cmd_step;
                        state    <= SYNC;
                    end
                end
                SYNC: begin
                    // abort beats a coincident last_cycle; latched period is dropped.
                    if (abort) begin
                        state <= IDLE;
                    end else if (last_cycle) begin
                        wave_length <= lat_wl;
                        high_time   <= next_ht;
                        if (reach) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (last_cycle && step_en) begin
                        high_time <= next_ht;
                        if (reach) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - scoreboard bench for pwm_ramp_ctrl

module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_wave_length;
    logic [15:0] cmd_target;
    logic [15:0] cmd_step;
`ifdef PWM_RAMP_DWELL_EN
    logic [7:0]  cmd_dwell;
`endif
    logic        abort;
    logic        last_cycle;
    logic [15:0] wave_length;
    logic [15:0] high_time;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] ht;
        logic [15:0] wl;
        logic        dn;
        logic        bz;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    int m_ht, m_wl, m_tgt, m_step, m_wlat, m_state, m_dwell, m_cnt;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.WIDTH(16), .WL_RESET(16'hFFFF)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_wave_length (cmd_wave_length),
        .cmd_target      (cmd_target),
        .cmd_step        (cmd_step),
`ifdef PWM_RAMP_DWELL_EN
        .cmd_dwell       (cmd_dwell),
`endif
        .abort           (abort),
        .last_cycle      (last_cycle),
        .wave_length     (wave_length),
        .high_time       (high_time),
        .busy            (busy),
        .done            (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_next(input int ht, input int tgt, input int stp);
        if (stp == 0 || tgt == ht) return tgt;
        if (tgt > ht) return (ht + stp >= tgt) ? tgt : ht + stp;
        return (ht - stp <= tgt) ? tgt : ht - stp;
    endfunction

    task automatic cmd(input int wl, input int tgt, input int stp, input int dw);
        cmd_valid       = 1'b1;
        cmd_wave_length = 16'(wl);
        cmd_target      = 16'(tgt);
        cmd_step        = 16'(stp);
`ifdef PWM_RAMP_DWELL_EN
        cmd_dwell       = 8'(dw);
`endif
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        m_wlat = wl; m_tgt = tgt; m_step = stp; m_state = 1;
`ifdef PWM_RAMP_DWELL_EN
        m_dwell = dw;
`else
        m_dwell = 0;
`endif
        m_cnt = 0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ready", 32'(cmd_ready), 32'd0);
    endtask

    // One PWM period boundary: model predicts, pushes, DUT edge, pop+compare.
    task automatic pulse(input string tag);
        exp_t e;
        int   nx;
        bit   dn = 0;
        if (m_state == 1) begin
            nx = model_next(m_ht, m_tgt, m_step);
            m_wl = m_wlat; m_ht = nx; m_cnt = 0;
            if (nx == m_tgt) begin dn = 1; m_state = 0; end else m_state = 2;
        end else if (m_state == 2) begin
            if (m_cnt >= m_dwell) begin
                nx = model_next(m_ht, m_tgt, m_step);
                m_ht = nx; m_cnt = 0;
                if (nx == m_tgt) begin dn = 1; m_state = 0; end
            end else begin
                m_cnt++;
            end
        end
        e.ht = 16'(m_ht); e.wl = 16'(m_wl); e.dn = dn; e.bz = (m_state != 0);
        sb.push_back(e);
        last_cycle = 1'b1;
        @(posedge clk); #1;
        last_cycle = 1'b0;
        e = sb.pop_front();
        chk({tag, "_ht"}, 32'(high_time), 32'(e.ht));
        chk({tag, "_wl"}, 32'(wave_length), 32'(e.wl));
        chk({tag, "_done"}, 32'(done), 32'(e.dn));
        chk({tag, "_busy"}, 32'(busy), 32'(e.bz));
    endtask

    task automatic idle_tick(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_ht_hold"}, 32'(high_time), 32'(m_ht));
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        m_state = 0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ht", 32'(high_time), 32'(m_ht));
        chk("abort_wl", 32'(wave_length), 32'(m_wl));
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; last_cycle = 1'b0;
        cmd_wave_length = '0; cmd_target = '0; cmd_step = '0;
`ifdef PWM_RAMP_DWELL_EN
        cmd_dwell = '0;
`endif
        m_ht = 0; m_wl = 16'hFFFF; m_state = 0; m_dwell = 0; m_cnt = 0;
        m_tgt = 0; m_step = 0; m_wlat = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_wl", 32'(wave_length), 32'hFFFF);
        chk("rst_ht", 32'(high_time), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) pulse("idle");

        // Ramp up 0 -> 40 by 10
        cmd(99, 40, 10, 0);
        for (int i = 0; i < 4; i++) pulse("up");
        idle_tick("up_end");

        // Ramp down 40 -> 5 by 10, saturating at target
        cmd(99, 5, 10, 0);
        for (int i = 0; i < 4; i++) pulse("down");
        idle_tick("down_end");

        // Near full scale: jump to 16'hFFE0, then step 0x20 toward 16'hFFF0
        cmd(99, 16'hFFE0, 0, 0);
        pulse("jump");
        cmd(99, 16'hFFF0, 16'h0020, 0);
        pulse("top");
        idle_tick("top_end");

        // Back to 0, then abort a ramp to 40 one cycle after the second step
        cmd(99, 0, 0, 0);
        pulse("zero");
        cmd(77, 40, 10, 0);
        pulse("ab1");
        pulse("ab2");
        cmd_valid = 1'b1; cmd_wave_length = 16'd5; cmd_target = 16'd1; cmd_step = 16'd1;
        @(posedge clk); #1;
        chk("busy_ignore_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        do_abort();
        pulse("post_abort");

        // abort coincident with last_cycle in RAMP: no step
        cmd(77, 40, 10, 0);
        pulse("co1");
        abort = 1'b1; last_cycle = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; last_cycle = 1'b0; m_state = 0;
        chk("co_abort_ht", 32'(high_time), 32'(m_ht));
        chk("co_abort_busy", 32'(busy), 32'd0);

        // abort in SYNC: latched period discarded
        cmd(55, 0, 0, 0);
        do_abort();
        pulse("sync_abort");

`ifdef PWM_RAMP_DWELL_EN
        cmd(99, 0, 0, 0);
        pulse("dw_zero");
        cmd(99, 20, 10, 2);
        for (int i = 0; i < 4; i++) pulse("dwell");
        chk("dwell_final", 32'(high_time), 32'd20);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
